obj_hit_ctl: RTL

OBJ_HIT_CTL -- requirements
Module: obj_hit_ctl

---
 rtl/obj_hit_ctl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/obj_hit_ctl.sv
// Spawn / hit / respawn sequencer for a single on-screen object.
// Owns spawn placement (LFSR-driven), bullet hit detection, kill scoring and hold timing.
module obj_hit_ctl #(
    parameter int unsigned HIT_R       = 8,
    parameter int unsigned SPAWN_HOLD  = 64,
    parameter int unsigned ELI_HOLD    = 6,
    parameter int unsigned RESPAWN_GAP = 128,
    parameter logic [5:0]  LIFES       = 6'd3,
    parameter logic [8:0]  MARGIN      = 9'd32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [8:0] blt_x,
    input  logic [8:0] blt_y,
    input  logic       blt_vi,
    input  logic [8:0] obj_x,
    input  logic [8:0] obj_y,
    input  logic       obj_vi,
    input  logic [5:0] obj_lifes,
    output logic       rst_obj,
    output logic [8:0] rst_x,
    output logic [8:0] rst_y,
    output logic [5:0] rst_lifes,
    output logic       x_am,
    output logic       y_am,
    output logic       eli,
    output logic       hit_ack,
    output logic [7:0] score,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_ALIVE = 3'd2,
        S_HIT   = 3'd3,
        S_COOL  = 3'd4,
        S_DEAD  = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_lfsr;
    logic        r_rst_obj;
    logic [8:0]  r_rst_x;
    logic [8:0]  r_rst_y;
    logic        r_x_am;
    logic        r_y_am;
    logic        r_eli;
    logic        r_hit_ack;
    logic [7:0]  r_score;

    logic        w_fb;
    logic [9:0]  w_bx;
    logic [9:0]  w_by;
    logic [9:0]  w_ox;
    logic [9:0]  w_oy;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic        w_overlap;
    logic [8:0]  w_spawn_x;
    logic [8:0]  w_spawn_y;
    logic        w_spawn_xam;
    logic        w_spawn_yam;
    logic [7:0]  w_score_inc;

    // Fibonacci taps 16,14,13,11 expressed as a right-shift register
    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Widened to 10 bits so |a-b| never wraps at the screen edges
    assign w_bx = {1'b0, blt_x};
    assign w_by = {1'b0, blt_y};
    assign w_ox = {1'b0, obj_x};
    assign w_oy = {1'b0, obj_y};
    assign w_dx = (w_bx >= w_ox) ? (w_bx - w_ox) : (w_ox - w_bx);
    assign w_dy = (w_by >= w_oy) ? (w_by - w_oy) : (w_oy - w_by);

    assign w_overlap = blt_vi & obj_vi & (w_dx <= 10'(HIT_R)) & (w_dy <= 10'(HIT_R));

    assign w_spawn_x   = {1'b0, r_lfsr[7:0]} + MARGIN;
    assign w_spawn_y   = {2'b00, r_lfsr[15:9]} + MARGIN;
    assign w_spawn_xam = r_lfsr[0] ^ r_lfsr[15];
    assign w_spawn_yam = r_lfsr[1];

    assign w_score_inc = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_lfsr    <= 16'hACE1;
            r_rst_obj <= 1'b0;
            r_rst_x   <= '0;
            r_rst_y   <= '0;
            r_x_am    <= 1'b0;
            r_y_am    <= 1'b0;
            r_eli     <= 1'b0;
            r_hit_ack <= 1'b0;
            r_score   <= '0;
        end else begin
            r_lfsr    <= {w_fb, r_lfsr[15:1]};
            r_hit_ack <= 1'b0;
            r_cnt     <= r_cnt + 16'd1;

            if (stop) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_rst_obj <= 1'b0;
                r_eli     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt     <= '0;
                        r_rst_obj <= 1'b0;
                        r_eli     <= 1'b0;
                        if (start) begin
                            r_state   <= S_SPAWN;
                            r_rst_obj <= 1'b1;
                            r_rst_x   <= w_spawn_x;
                            r_rst_y   <= w_spawn_y;
                            r_x_am    <= w_spawn_xam;
                            r_y_am    <= w_spawn_yam;
                        end
                    end

                    S_SPAWN: begin
                        if (r_cnt == 16'(SPAWN_HOLD - 1)) begin
                            r_state   <= S_ALIVE;
                            r_cnt     <= '0;
                            r_rst_obj <= 1'b0;
                        end
                    end

                    // A hit wins over a simultaneous zero-life death
                    S_ALIVE: begin
                        r_cnt <= '0;
                        if (w_overlap) begin
                            r_state   <= S_HIT;
                            r_eli     <= 1'b1;
                            r_hit_ack <= 1'b1;
                        end else if (obj_lifes == 6'd0) begin
                            r_state <= S_DEAD;
                            r_score <= w_score_inc;
                        end
                    end

                    S_HIT: begin
                        if (r_cnt == 16'(ELI_HOLD - 1)) begin
                            r_state <= S_COOL;
                            r_cnt   <= '0;
                            r_eli   <= 1'b0;
                        end
                    end

                    S_COOL: begin
                        if (r_cnt == 16'(ELI_HOLD - 1)) begin
                            r_cnt <= '0;
                            if (obj_lifes == 6'd0) begin
                                r_state <= S_DEAD;
                                r_score <= w_score_inc;
                            end else begin
                                r_state <= S_ALIVE;
                            end
                        end
                    end

                    S_DEAD: begin
                        if (r_cnt == 16'(RESPAWN_GAP - 1)) begin
                            r_state   <= S_SPAWN;
                            r_cnt     <= '0;
                            r_rst_obj <= 1'b1;
                            r_rst_x   <= w_spawn_x;
                            r_rst_y   <= w_spawn_y;
                            r_x_am    <= w_spawn_xam;
                            r_y_am    <= w_spawn_yam;
                        end
                    end

                    default: begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_rst_obj <= 1'b0;
                        r_eli     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rst_obj   = r_rst_obj;
    assign rst_x     = r_rst_x;
    assign rst_y     = r_rst_y;
    assign rst_lifes = LIFES;
    assign x_am      = r_x_am;
    assign y_am      = r_y_am;
    assign eli       = r_eli;
    assign hit_ack   = r_hit_ack;
    assign score     = r_score;
    assign state_o   = r_state;

endmodule
